// File: rtl/overcurrent_guard_x3.sv
// Three-channel overcurrent guard: periodic sampling, consecutive-sample trip qualification,
// hysteretic release after a hold-off, and bounded auto-retry ending in a latched lockout.
module overcurrent_guard_x3 #(
   parameter logic [15:0] THRESH_TRIP   = 16'h0258,
   parameter logic [15:0] THRESH_CLEAR  = 16'h01F4,
   parameter int unsigned SAMPLE_DIV    = 500000,
   parameter int unsigned TRIP_COUNT    = 3,
   parameter int unsigned HOLDOFF       = 200,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned CLEAN_SAMPLES = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] s1,
   input  logic [15:0] s2,
   input  logic [15:0] s3,
   input  logic        clear_lockout,
   output logic        relay1,
   output logic        relay2,
   output logic        relay3,
   output logic [2:0]  tripped,
   output logic [2:0]  lockout,
   output logic        sample_tick
);

   localparam int unsigned CntW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned OverW  = $clog2(TRIP_COUNT + 1);
   localparam int unsigned HoldW  = $clog2(HOLDOFF + 1);
   localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
   localparam int unsigned CleanW = $clog2(CLEAN_SAMPLES + 1);

   localparam logic [CntW-1:0]   CntLast   = CntW'(SAMPLE_DIV - 1);
   localparam logic [OverW-1:0]  OverLast  = OverW'(TRIP_COUNT - 1);
   localparam logic [HoldW-1:0]  HoldMax   = HoldW'(HOLDOFF);
   localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRIES);
   localparam logic [CleanW-1:0] CleanLast = CleanW'(CLEAN_SAMPLES - 1);

   typedef enum logic [1:0] {StArmed, StPending, StTripped, StLockout} state_e;

   logic [CntW-1:0]   cnt_q;
   logic              tick_q;
   logic [15:0]       s_arr   [3];
   state_e            state_q [3];
   state_e            state_d [3];
   logic [OverW-1:0]  over_q  [3];
   logic [OverW-1:0]  over_d  [3];
   logic [HoldW-1:0]  hold_q  [3];
   logic [HoldW-1:0]  hold_d  [3];
   logic [RetryW-1:0] retry_q [3];
   logic [RetryW-1:0] retry_d [3];
   logic [CleanW-1:0] clean_q [3];
   logic [CleanW-1:0] clean_d [3];
   logic [2:0]        trip_q, trip_d;
   logic [2:0]        lock_q, lock_d;

   assign s_arr[0] = s1;
   assign s_arr[1] = s2;
   assign s_arr[2] = s3;

   function automatic logic [RetryW-1:0] retry_sat(input logic [RetryW-1:0] r);
      return (r == RetryMax) ? r : r + RetryW'(1);
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         state_d[i] = state_q[i];
         over_d[i]  = over_q[i];
         hold_d[i]  = hold_q[i];
         retry_d[i] = retry_q[i];
         clean_d[i] = clean_q[i];
         unique case (state_q[i])
            StArmed: begin
               if (tick_q) begin
                  if (s_arr[i] > THRESH_TRIP) begin
                     clean_d[i] = '0;
                     if (TRIP_COUNT == 1) begin
                        state_d[i] = StTripped;
                        hold_d[i]  = '0;
                        over_d[i]  = '0;
                        retry_d[i] = retry_sat(retry_q[i]);
                     end else begin
                        state_d[i] = StPending;
                        over_d[i]  = OverW'(1);
                     end
                  end else if (clean_q[i] == CleanLast) begin
                     // A long enough clean run forgives earlier trips.
                     clean_d[i] = '0;
                     retry_d[i] = '0;
                  end else begin
                     clean_d[i] = clean_q[i] + CleanW'(1);
                  end
               end
            end
            StPending: begin
               if (tick_q) begin
                  if (s_arr[i] > THRESH_TRIP) begin
                     if (over_q[i] == OverLast) begin
                        state_d[i] = StTripped;
                        hold_d[i]  = '0;
                        over_d[i]  = '0;
                        retry_d[i] = retry_sat(retry_q[i]);
                     end else begin
                        over_d[i] = over_q[i] + OverW'(1);
                     end
                  end else begin
                     state_d[i] = StArmed;
                     over_d[i]  = '0;
                  end
               end
            end
            StTripped: begin
               if (tick_q) begin
                  if (hold_q[i] == HoldMax) begin
                     if (s_arr[i] <= THRESH_CLEAR) begin
                        if (retry_q[i] >= RetryMax) begin
                           state_d[i] = StLockout;
                        end else begin
                           state_d[i] = StArmed;
                           clean_d[i] = '0;
                        end
                     end
                  end else begin
                     hold_d[i] = hold_q[i] + HoldW'(1);
                  end
               end
            end
            StLockout: begin
               // Ticks are ignored; only an explicit clear releases the channel.
               if (clear_lockout) begin
                  state_d[i] = StArmed;
                  over_d[i]  = '0;
                  hold_d[i]  = '0;
                  retry_d[i] = '0;
                  clean_d[i] = '0;
               end
            end
         endcase
         trip_d[i] = (state_d[i] == StTripped) || (state_d[i] == StLockout);
         lock_d[i] = (state_d[i] == StLockout);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         trip_q <= '0;
         lock_q <= '0;
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= StArmed;
            over_q[i]  <= '0;
            hold_q[i]  <= '0;
            retry_q[i] <= '0;
            clean_q[i] <= '0;
         end
      end else begin
         cnt_q  <= (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
         tick_q <= (cnt_q == CntLast);
         trip_q <= trip_d;
         lock_q <= lock_d;
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= state_d[i];
            over_q[i]  <= over_d[i];
            hold_q[i]  <= hold_d[i];
            retry_q[i] <= retry_d[i];
            clean_q[i] <= clean_d[i];
         end
      end
   end

   assign relay1      = trip_q[0];
   assign relay2      = trip_q[1];
   assign relay3      = trip_q[2];
   assign tripped     = trip_q;
   assign lockout     = lock_q;
   assign sample_tick = tick_q;

endmodule

// File: tb/tb_overcurrent_guard_x3.sv
// Bench for overcurrent_guard_x3: per-tick stimulus plans, expected outputs queued at drive time
// and popped once the DUT has acted on the tick.
module tb_overcurrent_guard_x3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] s1 = '0, s2 = '0, s3 = '0;
   logic        clear_lockout = 1'b0;
   logic        relay1, relay2, relay3;
   logic [2:0]  tripped, lockout;
   logic        sample_tick;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] trip;
      logic [2:0] lock;
   } exp_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic        clr;
      logic [2:0]  trip;
      logic [2:0]  lock;
   } step_t;

   exp_t  sb [$];
   step_t plan [$];

   overcurrent_guard_x3 #(
      .THRESH_TRIP   (16'h0258),
      .THRESH_CLEAR  (16'h01F4),
      .SAMPLE_DIV    (4),
      .TRIP_COUNT    (3),
      .HOLDOFF       (5),
      .MAX_RETRIES   (2),
      .CLEAN_SAMPLES (6)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s1            (s1),
      .s2            (s2),
      .s3            (s3),
      .clear_lockout (clear_lockout),
      .relay1        (relay1),
      .relay2        (relay2),
      .relay3        (relay3),
      .tripped       (tripped),
      .lockout       (lockout),
      .sample_tick   (sample_tick)
   );

   always #5 clk = ~clk;

   task automatic add(input int n, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic clr, input logic [2:0] tr,
                      input logic [2:0] lk);
      step_t st;
      st = '{a: a, b: b, c: c, clr: clr, trip: tr, lock: lk};
      repeat (n) plan.push_back(st);
   endtask

   // Channel 2 locks out on the 18th tick while channel 1 trips on the same tick.
   task automatic add_lock_seq();
      add(2, 16'd0,   16'd601, 16'd0, 1'b0, 3'b000, 3'b000);
      add(1, 16'd0,   16'd601, 16'd0, 1'b0, 3'b010, 3'b000);
      add(5, 16'd0,   16'd0,   16'd0, 1'b0, 3'b010, 3'b000);
      add(1, 16'd0,   16'd0,   16'd0, 1'b0, 3'b000, 3'b000);
      add(2, 16'd0,   16'd601, 16'd0, 1'b0, 3'b000, 3'b000);
      add(1, 16'd0,   16'd601, 16'd0, 1'b0, 3'b010, 3'b000);
      add(3, 16'd0,   16'd0,   16'd0, 1'b0, 3'b010, 3'b000);
      add(2, 16'd601, 16'd0,   16'd0, 1'b0, 3'b010, 3'b000);
      add(1, 16'd601, 16'd0,   16'd0, 1'b0, 3'b011, 3'b010);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      s1 = '0; s2 = '0; s3 = '0;
      clear_lockout = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      plan.delete();
   endtask

   // Drives one step's inputs into the next tick cycle, queues its expectation, waits the edge.
   task automatic drive_tick(input step_t st, output bit ok);
      exp_t e;
      int   n;
      @(negedge clk);
      s1 = st.a; s2 = st.b; s3 = st.c;
      n = 0;
      while (sample_tick !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      ok = (sample_tick === 1'b1);
      clear_lockout = st.clr;
      e.trip = st.trip;
      e.lock = st.lock;
      sb.push_back(e);
      @(posedge clk);
      #1;
      clear_lockout = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      s1 = 16'hFFFF;
      repeat (3) @(negedge clk);
      checks++; if ({relay3, relay2, relay1} !== 3'b000) begin errors++;
         $display("FAIL reset relays: got %b want 000", {relay3, relay2, relay1}); end
      checks++; if (tripped !== 3'b000) begin errors++;
         $display("FAIL reset tripped: got %b want 000", tripped); end
      checks++; if (lockout !== 3'b000) begin errors++;
         $display("FAIL reset lockout: got %b want 000", lockout); end
      checks++; if (sample_tick !== 1'b0) begin errors++;
         $display("FAIL reset sample_tick: got %b want 0", sample_tick); end
      rst_n = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (sample_tick !== 1'b1 && n < 20);
      checks++; if (n !== 4) begin errors++;
         $display("FAIL first_tick edges: got %0d want 4", n); end
      @(posedge clk);
      #1;
      n = 1;
      checks++; if (sample_tick !== 1'b0) begin errors++;
         $display("FAIL tick_width: got %b want 0", sample_tick); end
      while (sample_tick !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++; if (n !== 4) begin errors++;
         $display("FAIL tick_period edges: got %0d want 4", n); end
   endtask

   task automatic test_trip_qual();
      exp_t e;
      bit   ok;
      apply_reset();
      add(2, 16'd601, 16'd0, 16'd600, 1'b0, 3'b000, 3'b000);
      add(1, 16'd600, 16'd0, 16'd600, 1'b0, 3'b000, 3'b000);
      add(2, 16'd601, 16'd0, 16'd600, 1'b0, 3'b000, 3'b000);
      add(1, 16'd601, 16'd0, 16'd600, 1'b0, 3'b001, 3'b000);
      foreach (plan[i]) begin
         drive_tick(plan[i], ok);
         e = sb.pop_front();
         checks++; if (!ok) begin errors++;
            $display("FAIL trip_qual tick step %0d: got none want pulse", i); end
         checks++; if ({relay3, relay2, relay1} !== e.trip) begin errors++;
            $display("FAIL trip_qual relays step %0d: got %b want %b", i,
                     {relay3, relay2, relay1}, e.trip); end
         checks++; if (tripped !== e.trip) begin errors++;
            $display("FAIL trip_qual tripped step %0d: got %b want %b", i, tripped, e.trip); end
         checks++; if (lockout !== e.lock) begin errors++;
            $display("FAIL trip_qual lockout step %0d: got %b want %b", i, lockout, e.lock); end
      end
   endtask

   task automatic test_hysteresis();
      exp_t e;
      bit   ok;
      for (int pass = 0; pass < 2; pass++) begin
         apply_reset();
         add(2, 16'd601, 16'd0, 16'd0, 1'b0, 3'b000, 3'b000);
         add(1, 16'd601, 16'd0, 16'd0, 1'b0, 3'b001, 3'b000);
         if (pass == 0) begin
            add(8, 16'd550, 16'd0, 16'd0, 1'b0, 3'b001, 3'b000);
         end else begin
            add(5, 16'd500, 16'd0, 16'd0, 1'b0, 3'b001, 3'b000);
         end
         add(1, 16'd500, 16'd0, 16'd0, 1'b0, 3'b000, 3'b000);
         foreach (plan[i]) begin
            drive_tick(plan[i], ok);
            e = sb.pop_front();
            checks++; if (!ok) begin errors++;
               $display("FAIL hysteresis tick p%0d step %0d: got none want pulse", pass, i); end
            checks++; if ({relay3, relay2, relay1} !== e.trip) begin errors++;
               $display("FAIL hysteresis relays p%0d step %0d: got %b want %b", pass, i,
                        {relay3, relay2, relay1}, e.trip); end
            checks++; if (lockout !== e.lock) begin errors++;
               $display("FAIL hysteresis lockout p%0d step %0d: got %b want %b", pass, i,
                        lockout, e.lock); end
         end
      end
   endtask

   task automatic test_retry_exhaust();
      exp_t e;
      bit   ok;
      apply_reset();
      add(2, 16'd0, 16'd601, 16'd0, 1'b0, 3'b000, 3'b000);
      add(1, 16'd0, 16'd601, 16'd0, 1'b0, 3'b010, 3'b000);
      add(5, 16'd0, 16'd0,   16'd0, 1'b0, 3'b010, 3'b000);
      add(3, 16'd0, 16'd0,   16'd0, 1'b0, 3'b000, 3'b000);
      add(2, 16'd0, 16'd601, 16'd0, 1'b0, 3'b000, 3'b000);
      add(1, 16'd0, 16'd601, 16'd0, 1'b0, 3'b010, 3'b000);
      add(5, 16'd0, 16'd0,   16'd0, 1'b0, 3'b010, 3'b000);
      add(5, 16'd0, 16'd0,   16'd0, 1'b0, 3'b010, 3'b010);
      foreach (plan[i]) begin
         drive_tick(plan[i], ok);
         e = sb.pop_front();
         checks++; if (!ok) begin errors++;
            $display("FAIL retry tick step %0d: got none want pulse", i); end
         checks++; if ({relay3, relay2, relay1} !== e.trip) begin errors++;
            $display("FAIL retry relays step %0d: got %b want %b", i,
                     {relay3, relay2, relay1}, e.trip); end
         checks++; if (lockout !== e.lock) begin errors++;
            $display("FAIL retry lockout step %0d: got %b want %b", i, lockout, e.lock); end
      end
      // Clear pulse away from a tick.
      @(negedge clk);
      if (sample_tick === 1'b1) @(negedge clk);
      clear_lockout = 1'b1;
      sb.push_back('{trip: 3'b000, lock: 3'b000});
      @(posedge clk);
      #1;
      clear_lockout = 1'b0;
      e = sb.pop_front();
      checks++; if (relay2 !== e.trip[1]) begin errors++;
         $display("FAIL clear relay2: got %b want %b", relay2, e.trip[1]); end
      checks++; if (lockout !== e.lock) begin errors++;
         $display("FAIL clear lockout: got %b want %b", lockout, e.lock); end
   endtask

   task automatic test_forgiveness();
      exp_t e;
      bit   ok;
      apply_reset();
      for (int t = 0; t < 3; t++) begin
         add(2, 16'd0, 16'd0, 16'd601, 1'b0, 3'b000, 3'b000);
         add(1, 16'd0, 16'd0, 16'd601, 1'b0, 3'b100, 3'b000);
         add(5, 16'd0, 16'd0, 16'd0,   1'b0, 3'b100, 3'b000);
         if (t < 2) add(1, 16'd0, 16'd0, 16'd0, 1'b0, 3'b000, 3'b000);
         else       add(1, 16'd0, 16'd0, 16'd0, 1'b0, 3'b100, 3'b100);
         if (t == 0) add(6, 16'd0, 16'd0, 16'd0, 1'b0, 3'b000, 3'b000);
      end
      foreach (plan[i]) begin
         drive_tick(plan[i], ok);
         e = sb.pop_front();
         checks++; if (!ok) begin errors++;
            $display("FAIL forgive tick step %0d: got none want pulse", i); end
         checks++; if ({relay3, relay2, relay1} !== e.trip) begin errors++;
            $display("FAIL forgive relays step %0d: got %b want %b", i,
                     {relay3, relay2, relay1}, e.trip); end
         checks++; if (lockout !== e.lock) begin errors++;
            $display("FAIL forgive lockout step %0d: got %b want %b", i, lockout, e.lock); end
      end
   endtask

   task automatic test_clear_on_tick();
      exp_t e;
      bit   ok;
      apply_reset();
      add_lock_seq();
      add(1, 16'hFFFF, 16'hFFFF, 16'd0, 1'b1, 3'b001, 3'b000);
      add(2, 16'hFFFF, 16'hFFFF, 16'd0, 1'b0, 3'b001, 3'b000);
      add(1, 16'hFFFF, 16'hFFFF, 16'd0, 1'b0, 3'b011, 3'b000);
      foreach (plan[i]) begin
         drive_tick(plan[i], ok);
         e = sb.pop_front();
         checks++; if (!ok) begin errors++;
            $display("FAIL clr_tick tick step %0d: got none want pulse", i); end
         checks++; if (tripped !== e.trip) begin errors++;
            $display("FAIL clr_tick tripped step %0d: got %b want %b", i, tripped, e.trip); end
         checks++; if (lockout !== e.lock) begin errors++;
            $display("FAIL clr_tick lockout step %0d: got %b want %b", i, lockout, e.lock); end
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      bit   ok;
      apply_reset();
      add_lock_seq();
      foreach (plan[i]) begin
         drive_tick(plan[i], ok);
         e = sb.pop_front();
         checks++; if (!ok) begin errors++;
            $display("FAIL mid_reset tick step %0d: got none want pulse", i); end
         checks++; if ({relay3, relay2, relay1} !== e.trip) begin errors++;
            $display("FAIL mid_reset relays step %0d: got %b want %b", i,
                     {relay3, relay2, relay1}, e.trip); end
         checks++; if (lockout !== e.lock) begin errors++;
            $display("FAIL mid_reset lockout step %0d: got %b want %b", i, lockout, e.lock); end
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++; if ({relay3, relay2, relay1} !== 3'b000) begin errors++;
         $display("FAIL mid_reset relays_after: got %b want 000", {relay3, relay2, relay1}); end
      checks++; if (tripped !== 3'b000) begin errors++;
         $display("FAIL mid_reset tripped_after: got %b want 000", tripped); end
      checks++; if (lockout !== 3'b000) begin errors++;
         $display("FAIL mid_reset lockout_after: got %b want 000", lockout); end
      checks++; if (sample_tick !== 1'b0) begin errors++;
         $display("FAIL mid_reset tick_after: got %b want 0", sample_tick); end
   endtask

   initial begin
      test_reset();
      test_trip_qual();
      test_hysteresis();
      test_retry_exhaust();
      test_forgiveness();
      test_clear_on_tick();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
